cmd_mem_loader: RTL and testbench
=================================

# cmd_mem_loader

Streaming command-memory loader for multi-core simulation and hardware tops. It accepts a 32-bit word stream with a valid/ready handshake, parses packets of header, length and command data, and assembles MEM_TO_CMD words into full CMD_WIDTH commands. Each command is written to the command memory of one of N_CORES processor cores at auto-incrementing addresses. It sits between the host/testbench write port and the per-core `cmd_mem` banks, and replaces the single-core, full-width, unsequenced write path.

## Interface
- N_CORES, 4, number of processor cores / command memories
- CMD_WIDTH, 128, full command width
- MEM_WIDTH, 32, stream word width; MEM_TO_CMD = CMD_WIDTH/MEM_WIDTH (integer, ≥1)
- CMD_ADDR_WIDTH, 16, command memory address width
- CORE_ID_WIDTH, 8, core select field width in header
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load_enable  in  1  when low, wr_ready held low (stream paused)
- wr_data  in  MEM_WIDTH  stream word
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  loader accepts word; transfer when wr_valid & wr_ready
- cmd_write  out  CMD_WIDTH  assembled command, chunk 0 in LSBs
- cmd_write_addr  out  CMD_ADDR_WIDTH  target address
- cmd_write_enable  out  N_CORES  one-hot write strobe, bit = core id
- busy  out  1  packet in progress (state ≠ HDR)
- done  out  1  one-cycle pulse at packet end
- err  out  1  sticky error; cleared only by reset

## Operation
- FSM states: HDR, LEN, DATA, CSUM (CSUM present only with macro).
- HDR: accepted word = {core_id[CORE_ID_WIDTH], start_addr[CMD_ADDR_WIDTH]} in LSBs; upper bits ignored. → LEN.
- LEN: accepted word = command count (full MEM_WIDTH, unsigned). Count 0 → CSUM if compiled, else HDR with done. Otherwise → DATA.
- DATA: words accepted into chunk slot 0..MEM_TO_CMD-1 (slot counter wraps). On slot MEM_TO_CMD-1 handshake, the command is registered and written; address increments; command counter decrements. Last command → CSUM or HDR.
- Address increments modulo 2^CMD_ADDR_WIDTH; wrap from all-ones to 0 is legal and not an error.
- core_id ≥ N_CORES: packet still consumed in full, no write enable bits asserted, err set at header acceptance.
- wr_ready = load_enable & ~reset-state; no other backpressure (the output register frees every cycle).
- Deasserting load_enable mid-packet pauses; state, slot and partial chunks are retained.

## Timing
- Reset values: wr_ready 0, cmd_write 0, cmd_write_addr 0, cmd_write_enable 0, busy 0, done 0, err 0, state HDR, counters 0.
- Write latency: cmd_write/cmd_write_addr/cmd_write_enable valid exactly one cycle after the final-chunk handshake; enable high one cycle only. cmd_write and cmd_write_addr hold their value after the write.
- done: same cycle as the last write enable; for count 0, cycle after LEN handshake; with checksum, cycle after CSUM handshake.
- Back-to-back packets: HDR of the next packet accepted in the cycle after the final DATA/LEN/CSUM handshake with no bubble; done and the new header acceptance may coincide.
- Reset asserted mid-packet: immediate return to reset values; a partial command is discarded, not written.

## Configuration
- CMD_LOADER_CHECKSUM_EN defined: after the data (or after LEN when count = 0), one CSUM word is expected, equal to the XOR of all DATA words of the packet (0 for count 0). A mismatch sets err; writes already performed are not undone; done still pulses.
- Undefined: no CSUM state; the packet ends after the last DATA word.

## Structure
- Package `cmd_loader_pkg`: state enum (HDR, LEN, DATA, CSUM), header field offset localparams, MEM_TO_CMD derivation function.
- Sub-module `cmd_chunk_assembler`: slot counter plus chunk registers; emits the full command and a one-cycle `cmd_valid`. The top holds the FSM, the address/count counters, core decode and the checksum.

## Test plan
- Header {core 2, addr 0x0010}, count 2, 8 words 0x0..0x7 → core 2 strobes at addr 0x0010 with cmd 0x00000003_00000002_00000001_00000000, then 0x0011 with cmd 0x7_6_5_4 chunks; done on the second write.
- Header addr 0xFFFF, count 2 → writes at 0xFFFF then 0x0000; err stays 0.
- Header core 7 (N_CORES=4), count 1 + 4 words → no enable bits asserted, err=1, next packet to core 0 writes normally.
- wr_valid toggled every cycle with load_enable pulsed low mid-command → identical write data/address as continuous stream.
- Reset asserted after 2 of 4 chunks → no write; the next full packet writes correctly from chunk 0.
- With CMD_LOADER_CHECKSUM_EN: correct XOR → err 0, done after CSUM; wrong CSUM 0xDEADBEEF → err 1 after writes complete.

Source files
------------

// File: rtl/cmd_loader_pkg.sv
// ----------------------------------------------------------------------------
// cmd_loader_pkg
// Shared definitions for the streaming command-memory loader:
//   - state_e            : packet parser states (HDR, LEN, DATA, CSUM)
//   - HDR_ADDR_LSB       : bit offset of start_addr inside the header word
//   - hdr_core_lsb()     : bit offset of core_id inside the header word
//   - calc_mem_to_cmd()  : number of stream words per full command
// Optional feature macro: CMD_LOADER_CHECKSUM_EN (CSUM state only used then).
// ----------------------------------------------------------------------------
package cmd_loader_pkg;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

    // Header word layout: {core_id, start_addr}, start_addr in the LSBs.
    localparam int HDR_ADDR_LSB = 0;

    function automatic int hdr_core_lsb(input int addr_width);
        return HDR_ADDR_LSB + addr_width;
    endfunction

    function automatic int calc_mem_to_cmd(input int cmd_width, input int mem_width);
        return cmd_width / mem_width;
    endfunction

endpackage

// File: rtl/cmd_chunk_assembler.sv
// ----------------------------------------------------------------------------
// cmd_chunk_assembler
// Collects MEM_TO_CMD stream words into one CMD_WIDTH command (chunk 0 in
// the LSBs). The completed command is registered on the final-chunk word and
// o_cmd_valid pulses for one cycle; o_cmd holds its value afterwards.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   i_word            : accepted stream word
//   i_word_valid      : i_word is a DATA word accepted this cycle
//   o_last_slot       : the current slot is the final chunk of a command
//   o_cmd             : last completed command
//   o_cmd_valid       : one-cycle pulse when o_cmd was just updated
// ----------------------------------------------------------------------------
module cmd_chunk_assembler
    import cmd_loader_pkg::*;
#(
    parameter int CMD_WIDTH = 128,
    parameter int MEM_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MEM_WIDTH-1:0] i_word,
    input  logic                 i_word_valid,
    output logic                 o_last_slot,
    output logic [CMD_WIDTH-1:0] o_cmd,
    output logic                 o_cmd_valid
);

    localparam int MEM_TO_CMD = calc_mem_to_cmd(CMD_WIDTH, MEM_WIDTH);
    localparam int SLOT_W     = (MEM_TO_CMD > 1) ? $clog2(MEM_TO_CMD) : 1;

    logic [SLOT_W-1:0]    r_slot;
    logic [MEM_WIDTH-1:0] r_chunks [MEM_TO_CMD];
    logic [CMD_WIDTH-1:0] r_cmd;
    logic                 r_cmd_valid;
    logic [CMD_WIDTH-1:0] w_next_cmd;

    assign o_last_slot = (r_slot == SLOT_W'(MEM_TO_CMD - 1));
    assign o_cmd       = r_cmd;
    assign o_cmd_valid = r_cmd_valid;

    // The incoming word replaces its own slot so the final chunk lands in the
    // command in the same cycle it is accepted.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_next_cmd = '0;
        for (int i = 0; i < MEM_TO_CMD; i++) begin
            w_next_cmd[i*MEM_WIDTH +: MEM_WIDTH] = (r_slot == SLOT_W'(i)) ? i_word : r_chunks[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot      <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            // NOTE: the chunk store is a small flop array, so it is reset with the rest;
            // a partially collected command is therefore discarded by reset.
            for (int i = 0; i < MEM_TO_CMD; i++) begin
                r_chunks[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout sequential logic; the
            // default pulse value below is overridden later in the same block.
            r_cmd_valid <= 1'b0;
            if (i_word_valid) begin
                r_chunks[r_slot] <= i_word;
                if (o_last_slot) begin
                    r_slot      <= '0;
                    r_cmd       <= w_next_cmd;
                    r_cmd_valid <= 1'b1;
                end else begin
                    r_slot <= r_slot + SLOT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cmd_mem_loader.sv
// ----------------------------------------------------------------------------
// cmd_mem_loader
// Streaming loader: parses {header, length, data[, checksum]} packets from a
// 32-bit valid/ready stream and writes assembled commands into the command
// memory of one of N_CORES cores at auto-incrementing addresses.
// Optional feature macro: CMD_LOADER_CHECKSUM_EN -- a trailing CSUM word equal
// to the XOR of all DATA words is expected; a mismatch sets err.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   load_enable       : when low, wr_ready is held low (stream paused)
//   wr_data/wr_valid  : stream word and its valid
//   wr_ready          : loader accepts a word this cycle
//   cmd_write         : assembled command (chunk 0 in LSBs)
//   cmd_write_addr    : target address of the command
//   cmd_write_enable  : one-hot per-core write strobe
//   busy              : packet in progress (state != HDR)
//   done              : one-cycle pulse at packet end
//   err               : sticky error (bad core id or checksum mismatch)
// ----------------------------------------------------------------------------
module cmd_mem_loader
    import cmd_loader_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int CMD_WIDTH      = 128,
    parameter int MEM_WIDTH      = 32,
    parameter int CMD_ADDR_WIDTH = 16,
    parameter int CORE_ID_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_enable,
    input  logic [MEM_WIDTH-1:0]      wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic [CMD_WIDTH-1:0]      cmd_write,
    output logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr,
    output logic [N_CORES-1:0]        cmd_write_enable,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int CORE_LSB = hdr_core_lsb(CMD_ADDR_WIDTH);

    state_e                    r_state;
    logic [CMD_ADDR_WIDTH-1:0] r_addr;
    logic [CMD_ADDR_WIDTH-1:0] r_wr_addr;
    logic [MEM_WIDTH-1:0]      r_count;
    logic [N_CORES-1:0]        r_core_sel;
    logic                      r_done;
    logic                      r_err;
`ifdef CMD_LOADER_CHECKSUM_EN
    logic [MEM_WIDTH-1:0]      r_csum;
`endif

    logic                      w_accept;
    logic                      w_data_word;
    logic                      w_last_slot;
    logic                      w_last_cmd;
    logic                      w_cmd_valid;
    logic [CORE_ID_WIDTH-1:0]  w_hdr_core;
    logic [N_CORES-1:0]        w_hdr_sel;

    assign wr_ready    = load_enable & ~reset;
    assign w_accept    = wr_valid & wr_ready;
    assign w_data_word = w_accept && (r_state == ST_DATA);
    assign w_last_cmd  = (r_count == MEM_WIDTH'(1));
    assign w_hdr_core  = wr_data[CORE_LSB +: CORE_ID_WIDTH];

    // An out-of-range core id decodes to no bits set, which both suppresses
    // the writes of that packet and flags the error.
    always_comb begin
        w_hdr_sel = '0;
        for (int i = 0; i < N_CORES; i++) begin
            w_hdr_sel[i] = (w_hdr_core == CORE_ID_WIDTH'(i));
        end
    end

    cmd_chunk_assembler #(
        .CMD_WIDTH (CMD_WIDTH),
        .MEM_WIDTH (MEM_WIDTH)
    ) u_assembler (
        .clk          (clk),
        .reset        (reset),
        .i_word       (wr_data),
        .i_word_valid (w_data_word),
        .o_last_slot  (w_last_slot),
        .o_cmd        (cmd_write),
        .o_cmd_valid  (w_cmd_valid)
    );

    // r_core_sel only changes on the next header acceptance, which is at the
    // earliest the cycle the final write is presented, so the strobe is safe.
    assign cmd_write_enable = w_cmd_valid ? r_core_sel : '0;
    assign cmd_write_addr   = r_wr_addr;
    assign busy             = (r_state != ST_HDR);
    assign done             = r_done;
    assign err              = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_HDR;
            r_addr     <= '0;
            r_wr_addr  <= '0;
            r_count    <= '0;
            r_core_sel <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef CMD_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                unique case (r_state)
                    ST_HDR: begin
                        r_addr     <= wr_data[HDR_ADDR_LSB +: CMD_ADDR_WIDTH];
                        r_core_sel <= w_hdr_sel;
                        if (w_hdr_sel == '0) begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_LEN;
                    end
                    ST_LEN: begin
                        r_count <= wr_data;
`ifdef CMD_LOADER_CHECKSUM_EN
                        r_csum  <= '0;
                        r_state <= (wr_data == '0) ? ST_CSUM : ST_DATA;
`else
                        if (wr_data == '0) begin
                            r_state <= ST_HDR;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
`endif
                    end
                    ST_DATA: begin
`ifdef CMD_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ wr_data;
`endif
                        if (w_last_slot) begin
                            r_wr_addr <= r_addr;
                            r_addr    <= r_addr + CMD_ADDR_WIDTH'(1);
                            r_count   <= r_count - MEM_WIDTH'(1);
                            if (w_last_cmd) begin
`ifdef CMD_LOADER_CHECKSUM_EN
                                r_state <= ST_CSUM;
`else
                                r_state <= ST_HDR;
                                r_done  <= 1'b1;
`endif
                            end
                        end
                    end
                    default: begin
                        // ST_CSUM; unreachable without the checksum feature.
`ifdef CMD_LOADER_CHECKSUM_EN
                        if (wr_data != r_csum) begin
                            r_err <= 1'b1;
                        end
                        r_done <= 1'b1;
`endif
                        r_state <= ST_HDR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_cmd_mem_loader
// Directed self-checking bench for cmd_mem_loader (default parameters).
// Honours CMD_LOADER_CHECKSUM_EN: packets then carry a trailing XOR word.
// ----------------------------------------------------------------------------
module tb_cmd_mem_loader;

`ifdef CMD_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    localparam int  PKT_EXTRA    = CSUM_EN ? 1 : 0;
    localparam logic LAST_WR_DONE = CSUM_EN ? 1'b0 : 1'b1;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_enable;
    logic [31:0]  wr_data;
    logic         wr_valid;
    logic         wr_ready;
    logic [127:0] cmd_write;
    logic [15:0]  cmd_write_addr;
    logic [3:0]   cmd_write_enable;
    logic         busy;
    logic         done;
    logic         err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int done_cnt = 0;

    typedef struct {
        logic [3:0]   en;
        logic [15:0]  addr;
        logic [127:0] cmd;
        logic         done;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] data_q[$];

    cmd_mem_loader dut (
        .clk              (clk),
        .reset            (reset),
        .load_enable      (load_enable),
        .wr_data          (wr_data),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .cmd_write        (cmd_write),
        .cmd_write_addr   (cmd_write_addr),
        .cmd_write_enable (cmd_write_enable),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_write_enable != 4'b0000) begin
                wr_q.push_back('{en: cmd_write_enable, addr: cmd_write_addr,
                                 cmd: cmd_write, done: done});
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one word and returns #1 after the accepting edge; wr_valid stays high.
    task automatic send_word(input logic [31:0] w);
        bit ok;
        int guard;
        ok = 1'b0;
        guard = 0;
        wr_data  = w;
        wr_valid = 1'b1;
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = wr_ready;
            @(posedge clk);
            #1;
            if (ok) accept_cyc = cyc;
            guard++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_word_timeout: wr_ready=0 required=1 word=%h", w);
        end
    endtask

    // Sends header, count, data_q and (if compiled) the checksum word.
    task automatic send_packet(input logic [31:0] hdr, input logic [31:0] cnt,
                               input bit bad_csum);
        logic [31:0] x;
        x = 32'h0;
        send_word(hdr);
        send_word(cnt);
        foreach (data_q[i]) begin
            send_word(data_q[i]);
            x = x ^ data_q[i];
        end
        if (CSUM_EN) send_word(bad_csum ? 32'hDEADBEEF : x);
    endtask

    task automatic stop_stream();
        wr_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic clear_log();
        wr_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %b exp 0", wr_ready); end
        checks++; if (cmd_write !== 128'h0) begin errors++; $display("FAIL rst_cmd: got %h exp 0", cmd_write); end
        checks++; if (cmd_write_addr !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", cmd_write_addr); end
        checks++; if (cmd_write_enable !== 4'h0) begin errors++; $display("FAIL rst_en: got %b exp 0", cmd_write_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b exp 1", wr_ready); end
    endtask

    task automatic test_basic();
        clear_log();
        data_q = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        send_word(32'h0002_0010);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", busy); end
        data_q.delete();
        data_q = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        send_word(32'd2);
        foreach (data_q[i]) send_word(data_q[i]);
        if (CSUM_EN) send_word(32'h0);  // 0^1^..^7 = 0
        stop_stream();
        checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL basic_nwrites: got %0d exp 2", wr_q.size()); end
        if (wr_q.size() == 2) begin
            checks++; if (wr_q[0].en !== 4'b0100) begin errors++; $display("FAIL basic_en0: got %b exp 0100", wr_q[0].en); end
            checks++; if (wr_q[0].addr !== 16'h0010) begin errors++; $display("FAIL basic_addr0: got %h exp 0010", wr_q[0].addr); end
            checks++; if (wr_q[0].cmd !== 128'h00000003_00000002_00000001_00000000) begin errors++; $display("FAIL basic_cmd0: got %h exp 00000003000000020000000100000000", wr_q[0].cmd); end
            checks++; if (wr_q[0].done !== 1'b0) begin errors++; $display("FAIL basic_done0: got %b exp 0", wr_q[0].done); end
            checks++; if (wr_q[1].addr !== 16'h0011) begin errors++; $display("FAIL basic_addr1: got %h exp 0011", wr_q[1].addr); end
            checks++; if (wr_q[1].cmd !== 128'h00000007_00000006_00000005_00000004) begin errors++; $display("FAIL basic_cmd1: got %h exp 00000007000000060000000500000004", wr_q[1].cmd); end
            checks++; if (wr_q[1].done !== LAST_WR_DONE) begin errors++; $display("FAIL basic_done1: got %b exp %b", wr_q[1].done, LAST_WR_DONE); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d exp 1", done_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b exp 0", err); end
        checks++; if (cmd_write !== 128'h00000007_00000006_00000005_00000004) begin errors++; $display("FAIL basic_hold_cmd: got %h", cmd_write); end
        checks++; if (cmd_write_addr !== 16'h0011) begin errors++; $display("FAIL basic_hold_addr: got %h exp 0011", cmd_write_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b exp 0", busy); end
    endtask

    task automatic test_addr_wrap();
        clear_log();
        data_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
        send_packet(32'h0001_FFFF, 32'd2, 1'b0);
        stop_stream();
        checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL wrap_nwrites: got %0d exp 2", wr_q.size()); end
        if (wr_q.size() == 2) begin
            checks++; if (wr_q[0].addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr0: got %h exp ffff", wr_q[0].addr); end
            checks++; if (wr_q[1].addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr1: got %h exp 0000", wr_q[1].addr); end
            checks++; if (wr_q[1].en !== 4'b0010) begin errors++; $display("FAIL wrap_en1: got %b exp 0010", wr_q[1].en); end
            checks++; if (wr_q[1].cmd !== 128'h000000A7_000000A6_000000A5_000000A4) begin errors++; $display("FAIL wrap_cmd1: got %h", wr_q[1].cmd); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b exp 0", err); end
    endtask

    task automatic test_bad_core();
        clear_log();
        send_word(32'h0007_0000);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badcore_err_at_hdr: got %b exp 1", err); end
        send_word(32'd1);
        send_word(32'h1); send_word(32'h2); send_word(32'h3); send_word(32'h4);
        if (CSUM_EN) send_word(32'h4);  // 1^2^3^4 = 4
        data_q = '{32'h10, 32'h20, 32'h30, 32'h40};
        send_packet(32'h0000_0050, 32'd1, 1'b0);
        stop_stream();
        checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL badcore_nwrites: got %0d exp 1", wr_q.size()); end
        if (wr_q.size() == 1) begin
            checks++; if (wr_q[0].en !== 4'b0001) begin errors++; $display("FAIL badcore_next_en: got %b exp 0001", wr_q[0].en); end
            checks++; if (wr_q[0].addr !== 16'h0050) begin errors++; $display("FAIL badcore_next_addr: got %h exp 0050", wr_q[0].addr); end
            checks++; if (wr_q[0].cmd !== 128'h00000040_00000030_00000020_00000010) begin errors++; $display("FAIL badcore_next_cmd: got %h", wr_q[0].cmd); end
        end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL badcore_done_cnt: got %0d exp 2", done_cnt); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badcore_err_sticky: got %b exp 1", err); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL badcore_err_cleared: got %b exp 0", err); end
    endtask

    task automatic test_count_zero();
        clear_log();
        data_q.delete();
        send_packet(32'h0002_0070, 32'd0, 1'b0);
        stop_stream();
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL zero_nwrites: got %0d exp 0", wr_q.size()); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_cnt: got %0d exp 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b exp 0", busy); end
    endtask

    task automatic test_pause();
        clear_log();
        send_word(32'h0001_0020); wr_valid = 1'b0; tick();
        send_word(32'd1);         wr_valid = 1'b0; tick();
        send_word(32'hA);         wr_valid = 1'b0; tick();
        send_word(32'hB);
        load_enable = 1'b0;
        wr_data     = 32'hC;
        wr_valid    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL pause_ready: got %b exp 0", wr_ready); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pause_busy: got %b exp 1", busy); end
            @(posedge clk);
            #1;
        end
        load_enable = 1'b1;
        send_word(32'hC); wr_valid = 1'b0; tick();
        send_word(32'hD);
        if (CSUM_EN) send_word(32'h0);  // A^B^C^D = 0
        stop_stream();
        checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL pause_nwrites: got %0d exp 1", wr_q.size()); end
        if (wr_q.size() == 1) begin
            checks++; if (wr_q[0].en !== 4'b0010) begin errors++; $display("FAIL pause_en: got %b exp 0010", wr_q[0].en); end
            checks++; if (wr_q[0].addr !== 16'h0020) begin errors++; $display("FAIL pause_addr: got %h exp 0020", wr_q[0].addr); end
            checks++; if (wr_q[0].cmd !== 128'h0000000D_0000000C_0000000B_0000000A) begin errors++; $display("FAIL pause_cmd: got %h", wr_q[0].cmd); end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_word(32'h0000_0030);
        send_word(32'd1);
        send_word(32'h1);
        send_word(32'h2);
        wr_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b exp 0", busy); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b exp 0", wr_ready); end
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL midrst_no_write: got %0d exp 0", wr_q.size()); end
        data_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        send_packet(32'h0003_0040, 32'd1, 1'b0);
        stop_stream();
        checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL midrst_nwrites: got %0d exp 1", wr_q.size()); end
        if (wr_q.size() == 1) begin
            checks++; if (wr_q[0].en !== 4'b1000) begin errors++; $display("FAIL midrst_en: got %b exp 1000", wr_q[0].en); end
            checks++; if (wr_q[0].addr !== 16'h0040) begin errors++; $display("FAIL midrst_addr: got %h exp 0040", wr_q[0].addr); end
            checks++; if (wr_q[0].cmd !== 128'h00000044_00000033_00000022_00000011) begin errors++; $display("FAIL midrst_cmd: got %h", wr_q[0].cmd); end
        end
    endtask

    task automatic test_back_to_back();
        int first_cyc;
        clear_log();
        data_q = '{32'h1, 32'h2, 32'h3, 32'h4};
        send_word(32'h0000_0060);
        first_cyc = accept_cyc;
        send_word(32'd1);
        foreach (data_q[i]) send_word(data_q[i]);
        if (CSUM_EN) send_word(32'h4);  // 1^2^3^4
        data_q = '{32'h5, 32'h6, 32'h7, 32'h8};
        send_packet(32'h0001_0061, 32'd1, 1'b0);
        checks++; if (accept_cyc - first_cyc !== 11 + 2 * PKT_EXTRA) begin errors++; $display("FAIL b2b_cycles: got %0d exp %0d", accept_cyc - first_cyc, 11 + 2 * PKT_EXTRA); end
        stop_stream();
        checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL b2b_nwrites: got %0d exp 2", wr_q.size()); end
        if (wr_q.size() == 2) begin
            checks++; if (wr_q[0].cmd !== 128'h00000004_00000003_00000002_00000001) begin errors++; $display("FAIL b2b_cmd0: got %h", wr_q[0].cmd); end
            checks++; if (wr_q[1].en !== 4'b0010) begin errors++; $display("FAIL b2b_en1: got %b exp 0010", wr_q[1].en); end
            checks++; if (wr_q[1].addr !== 16'h0061) begin errors++; $display("FAIL b2b_addr1: got %h exp 0061", wr_q[1].addr); end
            checks++; if (wr_q[1].cmd !== 128'h00000008_00000007_00000006_00000005) begin errors++; $display("FAIL b2b_cmd1: got %h", wr_q[1].cmd); end
        end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d exp 2", done_cnt); end
    endtask

`ifdef CMD_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_log();
        data_q = '{32'h1, 32'h2, 32'h4, 32'h8};
        send_packet(32'h0000_0080, 32'd1, 1'b0);
        stop_stream();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL csum_good_err: got %b exp 0", err); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL csum_good_done: got %0d exp 1", done_cnt); end
        clear_log();
        send_packet(32'h0000_0081, 32'd1, 1'b1);
        stop_stream();
        checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL csum_bad_nwrites: got %0d exp 1", wr_q.size()); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL csum_bad_err: got %b exp 1", err); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL csum_bad_done: got %0d exp 1", done_cnt); end
        do_reset();
    endtask
`endif

    initial begin
        reset       = 1'b1;
        load_enable = 1'b1;
        wr_valid    = 1'b0;
        wr_data     = 32'h0;
        test_reset();
        tick();
        test_basic();
        test_addr_wrap();
        test_bad_core();
        test_count_zero();
        test_pause();
        test_reset_mid();
        test_back_to_back();
`ifdef CMD_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
